host_cmd_responder: RTL and testbench
=====================================

Name: host_cmd_responder

Overview:
- Target-side decoder for the host register protocol: cmd, address, data-in, start/end pointer, status and data-out registers.
- Turns host commands into code/string memory writes and reads.
- Starts the regex engine, tracks run status, and counts elapsed clock cycles.
- Sits between the AXI-Lite register file and the shared instruction/string BRAM plus the engine core.

Parameters:
- REG_WIDTH, 32, width of every host register and memory data word
- ADDR_WIDTH, 12, word-address width of the shared BRAM

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_register  in  REG_WIDTH  host command; encodings: NOP=0, WRITE=1, READ=2, START=3, RESET=4, READ_ELAPSED_CLOCK=5
- address_register  in  REG_WIDTH  word address; low ADDR_WIDTH bits are used
- data_in_register  in  REG_WIDTH  write data
- start_cc_pointer_register  in  REG_WIDTH  first string byte address
- end_cc_pointer_register  in  REG_WIDTH  last string byte address (inclusive)
- status_register  out  REG_WIDTH  status; IDLE=0, RUNNING=1, ACCEPTED=2, REJECTED=3, ERROR=4
- data_o_register  out  REG_WIDTH  read data or cycle count
- mem_we  out  1  BRAM write enable
- mem_addr  out  ADDR_WIDTH  BRAM word address
- mem_wdata  out  REG_WIDTH  BRAM write data
- mem_rdata  in  REG_WIDTH  BRAM read data, valid 1 cycle after mem_addr
- engine_start  out  1  one-cycle start pulse
- engine_abort  out  1  one-cycle abort pulse
- engine_start_cc  out  REG_WIDTH  latched start pointer
- engine_end_cc  out  REG_WIDTH  latched end pointer
- engine_done  in  1  engine finished, one-cycle pulse
- engine_accept  in  1  match result, qualified by engine_done

Behaviour:
- Reset (rst_n=0, async): every output 0, status IDLE, cycle counter 0, previous-cmd register NOP.
- Commands are sampled on every rising edge. Unknown encodings are treated as NOP.
- FSM states: IDLE, RUNNING, ACCEPTED, REJECTED, ERROR.
  - status_register is the state encoding, registered.
  - WRITE, READ and START are honoured in every state except RUNNING.
- WRITE (level-sensitive streaming):
  - Each cycle cmd==WRITE, register mem_we=1, mem_addr=address, mem_wdata=data_in, so the write hits BRAM 1 cycle after sampling.
  - Host may change address/data every cycle while WRITE is held; each sampled pair is written.
  - mem_we=0 on any other cmd.
- READ (level-sensitive):
  - mem_addr is registered from address at cycle N.
  - data_o_register <= mem_rdata at N+2, and updates every cycle while READ is held.
- START (edge-triggered: cmd==START and previous cmd!=START):
  - If end < start (unsigned): state ERROR, no engine_start.
  - Otherwise latch engine_start_cc/engine_end_cc, pulse engine_start for 1 cycle, clear the counter, state RUNNING next cycle.
  - Holding START does not retrigger.
- RUNNING:
  - Counter increments every cycle and saturates at all-ones.
  - WRITE, READ and START are ignored; mem_we is forced 0.
  - On engine_done the state becomes ACCEPTED (engine_accept=1) or REJECTED next cycle, and the counter freezes.
- READ_ELAPSED_CLOCK:
  - Allowed in any state; data_o_register <= counter value on the next edge.
  - A snapshot taken during RUNNING is legal.
- RESET command, from any state:
  - State becomes IDLE and the counter and data_o are cleared.
  - engine_abort pulses 1 cycle if the state was RUNNING.
  - Overrides a simultaneous engine_done.
- ACCEPTED/REJECTED/ERROR are held until RESET or a new START edge.
- engine_done outside RUNNING is ignored.

Test Plan:
- Reset mid-run: START with pointers 0x10/0x20, deassert rst_n 3 cycles later -> status=0, engine_start_cc=0, mem_we=0 immediately (async).
- Streamed write then read:
  - Write stimulus: WRITE held; addr 0,1,2 with data 0xA5A50001, 0xA5A50002, 0xA5A50003 on consecutive cycles -> three mem_we pulses with matching addr/data, each 1 cycle after sampling.
  - Readback stimulus: READ addr 1 -> data_o=0xA5A50002 at sample+2.
- Accept path: START with start=0x40, end=0x4F -> one engine_start pulse, status=1 next cycle. Bench asserts engine_done/accept=1 after 25 cycles -> status=2. READ_ELAPSED_CLOCK -> data_o=25 (±1 per defined edge alignment, checked exactly by scoreboard).
- Reject and re-arm: from ACCEPTED, NOP then START with engine_accept=0 at done -> status=3 and counter restarted from 0. START held 5 cycles -> exactly 1 engine_start.
- Guards during run: WRITE addr 5 data 0xDEAD while RUNNING -> mem_we stays 0. START with end=0x10 < start=0x20 from IDLE -> status=4, no engine_start.
- RESET vs done: CMD_RESET in the same cycle as engine_done -> status=0, engine_abort=1 for 1 cycle, counter=0.

Source files
------------

// File: rtl/host_cmd_responder.sv
// Host register command decoder: streams BRAM writes/reads, launches the engine and times the run.
// WRITE lands 1 cycle after sampling, READ data 2 cycles after; no backpressure, commands sampled every edge.
module host_cmd_responder #(
   parameter int REG_WIDTH  = 32,
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_WIDTH-1:0]  cmd_register,
   input  logic [REG_WIDTH-1:0]  address_register,
   input  logic [REG_WIDTH-1:0]  data_in_register,
   input  logic [REG_WIDTH-1:0]  start_cc_pointer_register,
   input  logic [REG_WIDTH-1:0]  end_cc_pointer_register,
   output logic [REG_WIDTH-1:0]  status_register,
   output logic [REG_WIDTH-1:0]  data_o_register,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [REG_WIDTH-1:0]  mem_wdata,
   input  logic [REG_WIDTH-1:0]  mem_rdata,
   output logic                  engine_start,
   output logic                  engine_abort,
   output logic [REG_WIDTH-1:0]  engine_start_cc,
   output logic [REG_WIDTH-1:0]  engine_end_cc,
   input  logic                  engine_done,
   input  logic                  engine_accept
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RUNNING  = 3'd1,
      ST_ACCEPTED = 3'd2,
      ST_REJECTED = 3'd3,
      ST_ERROR    = 3'd4
   } state_e;

   typedef enum logic [2:0] {
      CMD_NOP     = 3'd0,
      CMD_WRITE   = 3'd1,
      CMD_READ    = 3'd2,
      CMD_START   = 3'd3,
      CMD_RESET   = 3'd4,
      CMD_ELAPSED = 3'd5
   } cmd_e;

   state_e                state_q, state_d;
   cmd_e                  cmd, prev_cmd_q, prev_cmd_d;
   logic [REG_WIDTH-1:0]  counter_q, counter_d;
   logic [REG_WIDTH-1:0]  data_o_q, data_o_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [REG_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
   logic                  start_q, start_d;
   logic                  abort_q, abort_d;
   logic [REG_WIDTH-1:0]  start_cc_q, start_cc_d;
   logic [REG_WIDTH-1:0]  end_cc_q, end_cc_d;
   logic                  rd1_q, rd1_d;
   logic                  rd2_q, rd2_d;
   logic                  unused_addr_bits;

   assign unused_addr_bits = ^address_register[REG_WIDTH-1:ADDR_WIDTH];

   always_comb begin
      cmd = CMD_NOP;
      case (cmd_register)
         REG_WIDTH'(1): cmd = CMD_WRITE;
         REG_WIDTH'(2): cmd = CMD_READ;
         REG_WIDTH'(3): cmd = CMD_START;
         REG_WIDTH'(4): cmd = CMD_RESET;
         REG_WIDTH'(5): cmd = CMD_ELAPSED;
         default:       cmd = CMD_NOP;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      prev_cmd_d  = cmd;
      counter_d   = counter_q;
      data_o_d    = data_o_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      start_d     = 1'b0;
      abort_d     = 1'b0;
      start_cc_d  = start_cc_q;
      end_cc_d    = end_cc_q;
      rd1_d       = 1'b0;
      rd2_d       = rd1_q;

      // Read data returns two edges after the address was sampled.
      if (rd2_q) begin
         data_o_d = mem_rdata;
      end

      if (state_q == ST_RUNNING) begin
         if (counter_q != '1) begin
            counter_d = counter_q + 1'b1;
         end
         if (engine_done) begin
            state_d = engine_accept ? ST_ACCEPTED : ST_REJECTED;
         end
      end

      case (cmd)
         CMD_RESET: begin
            state_d   = ST_IDLE;
            counter_d = '0;
            data_o_d  = '0;
            abort_d   = (state_q == ST_RUNNING);
            rd1_d     = 1'b0;
            rd2_d     = 1'b0;
         end
         CMD_ELAPSED: begin
            data_o_d = counter_q;
         end
         CMD_WRITE: begin
            if (state_q != ST_RUNNING) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = address_register[ADDR_WIDTH-1:0];
               mem_wdata_d = data_in_register;
            end
         end
         CMD_READ: begin
            if (state_q != ST_RUNNING) begin
               mem_addr_d = address_register[ADDR_WIDTH-1:0];
               rd1_d      = 1'b1;
            end
         end
         CMD_START: begin
            if (state_q != ST_RUNNING && prev_cmd_q != CMD_START) begin
               if (end_cc_pointer_register < start_cc_pointer_register) begin
                  state_d = ST_ERROR;
               end else begin
                  state_d    = ST_RUNNING;
                  start_d    = 1'b1;
                  counter_d  = '0;
                  start_cc_d = start_cc_pointer_register;
                  end_cc_d   = end_cc_pointer_register;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         prev_cmd_q  <= CMD_NOP;
         counter_q   <= '0;
         data_o_q    <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         start_q     <= 1'b0;
         abort_q     <= 1'b0;
         start_cc_q  <= '0;
         end_cc_q    <= '0;
         rd1_q       <= 1'b0;
         rd2_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         prev_cmd_q  <= prev_cmd_d;
         counter_q   <= counter_d;
         data_o_q    <= data_o_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         start_q     <= start_d;
         abort_q     <= abort_d;
         start_cc_q  <= start_cc_d;
         end_cc_q    <= end_cc_d;
         rd1_q       <= rd1_d;
         rd2_q       <= rd2_d;
      end
   end

   assign status_register = {{(REG_WIDTH-3){1'b0}}, state_q};
   assign data_o_register = data_o_q;
   assign mem_we          = mem_we_q;
   assign mem_addr        = mem_addr_q;
   assign mem_wdata       = mem_wdata_q;
   assign engine_start    = start_q;
   assign engine_abort    = abort_q;
   assign engine_start_cc = start_cc_q;
   assign engine_end_cc   = end_cc_q;

endmodule

// File: tb/tb_host_cmd_responder.sv
// Directed bench for host_cmd_responder with a registered-read BRAM model.
module tb_host_cmd_responder;
   localparam int RW = 32;
   localparam int AW = 12;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [RW-1:0] cmd, addr, din, scc, ecc;
   logic [RW-1:0] status, data_o, mem_wdata, mem_rdata, start_cc, end_cc;
   logic          mem_we, engine_start, engine_abort, engine_done, engine_accept;
   logic [AW-1:0] mem_addr;
   logic [RW-1:0] mem [0:4095];

   int errors = 0;
   int checks = 0;
   int start_cnt = 0;
   int abort_cnt = 0;
   int we_cnt = 0;

   always #5 clk = ~clk;

   host_cmd_responder #(.REG_WIDTH(RW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_register(cmd), .address_register(addr), .data_in_register(din),
      .start_cc_pointer_register(scc), .end_cc_pointer_register(ecc),
      .status_register(status), .data_o_register(data_o),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .engine_start(engine_start), .engine_abort(engine_abort),
      .engine_start_cc(start_cc), .engine_end_cc(end_cc),
      .engine_done(engine_done), .engine_accept(engine_accept)
   );

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   always @(negedge clk) begin
      if (engine_start) start_cnt++;
      if (engine_abort) abort_cnt++;
      if (mem_we) we_cnt++;
   end

   // Inputs change and outputs are sampled 1 ns after the falling edge.
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (status !== 0) begin errors++; $display("FAIL reset_status got %0h want 0", status); end
      checks++; if (data_o !== 0) begin errors++; $display("FAIL reset_data_o got %0h want 0", data_o); end
      checks++; if (mem_we !== 0 || engine_start !== 0 || engine_abort !== 0) begin errors++; $display("FAIL reset_pulses got we=%b st=%b ab=%b want 0", mem_we, engine_start, engine_abort); end
      checks++; if (start_cc !== 0 || end_cc !== 0) begin errors++; $display("FAIL reset_cc got %0h/%0h want 0/0", start_cc, end_cc); end
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset_mid_run();
      scc = 32'h10; ecc = 32'h20; cmd = 3;
      step();
      checks++; if (status !== 1) begin errors++; $display("FAIL midrun_running got %0h want 1", status); end
      checks++; if (start_cc !== 32'h10) begin errors++; $display("FAIL midrun_latch got %0h want 10", start_cc); end
      cmd = 0;
      step(); step(); step();
      #1 rst_n = 1'b0;
      #1;
      checks++; if (status !== 0) begin errors++; $display("FAIL midrun_async_status got %0h want 0", status); end
      checks++; if (start_cc !== 0 || end_cc !== 0) begin errors++; $display("FAIL midrun_async_cc got %0h/%0h want 0/0", start_cc, end_cc); end
      checks++; if (mem_we !== 0) begin errors++; $display("FAIL midrun_async_we got %b want 0", mem_we); end
      #1 rst_n = 1'b1;
      step();
   endtask

   task automatic test_write_read();
      int w0;
      w0 = we_cnt;
      cmd = 1; addr = 0; din = 32'hA5A50001;
      step();
      checks++; if (mem_we !== 1 || mem_addr !== 0 || mem_wdata !== 32'hA5A50001) begin errors++; $display("FAIL wr0 got we=%b a=%0h d=%h want 1/0/a5a50001", mem_we, mem_addr, mem_wdata); end
      addr = 1; din = 32'hA5A50002;
      step();
      checks++; if (mem_we !== 1 || mem_addr !== 1 || mem_wdata !== 32'hA5A50002) begin errors++; $display("FAIL wr1 got we=%b a=%0h d=%h want 1/1/a5a50002", mem_we, mem_addr, mem_wdata); end
      addr = 2; din = 32'hA5A50003;
      step();
      checks++; if (mem_we !== 1 || mem_addr !== 2 || mem_wdata !== 32'hA5A50003) begin errors++; $display("FAIL wr2 got we=%b a=%0h d=%h want 1/2/a5a50003", mem_we, mem_addr, mem_wdata); end
      cmd = 0;
      step();
      checks++; if (mem_we !== 0) begin errors++; $display("FAIL wr_stop got %b want 0", mem_we); end
      checks++; if (we_cnt - w0 !== 3) begin errors++; $display("FAIL wr_count got %0d want 3", we_cnt - w0); end
      cmd = 2; addr = 1;
      step();
      checks++; if (mem_addr !== 1) begin errors++; $display("FAIL rd_addr got %0h want 1", mem_addr); end
      cmd = 0;
      step();
      checks++; if (data_o !== 0) begin errors++; $display("FAIL rd_early got %h want 0", data_o); end
      step();
      checks++; if (data_o !== 32'hA5A50002) begin errors++; $display("FAIL rd_data got %h want a5a50002", data_o); end
      cmd = 2; addr = 0;
      step();
      addr = 2;
      step();
      cmd = 0;
      step();
      checks++; if (data_o !== 32'hA5A50001) begin errors++; $display("FAIL rd_stream0 got %h want a5a50001", data_o); end
      step();
      checks++; if (data_o !== 32'hA5A50003) begin errors++; $display("FAIL rd_stream2 got %h want a5a50003", data_o); end
   endtask

   task automatic test_accept();
      int s0;
      s0 = start_cnt;
      scc = 32'h40; ecc = 32'h4F; cmd = 3;
      step();
      checks++; if (status !== 1 || engine_start !== 1) begin errors++; $display("FAIL acc_start got st=%0h pulse=%b want 1/1", status, engine_start); end
      checks++; if (start_cc !== 32'h40 || end_cc !== 32'h4F) begin errors++; $display("FAIL acc_latch got %0h/%0h want 40/4f", start_cc, end_cc); end
      cmd = 0;
      step();
      checks++; if (engine_start !== 0) begin errors++; $display("FAIL acc_pulse_len got %b want 0", engine_start); end
      repeat (23) step();
      engine_done = 1; engine_accept = 1;
      step();
      engine_done = 0; engine_accept = 0;
      checks++; if (status !== 2) begin errors++; $display("FAIL acc_status got %0h want 2", status); end
      cmd = 5;
      step();
      checks++; if (data_o !== 25) begin errors++; $display("FAIL acc_elapsed got %0d want 25", data_o); end
      cmd = 0; engine_done = 1;
      step();
      engine_done = 0;
      checks++; if (status !== 2) begin errors++; $display("FAIL acc_done_ignored got %0h want 2", status); end
      repeat (3) step();
      cmd = 5;
      step();
      checks++; if (data_o !== 25) begin errors++; $display("FAIL acc_frozen got %0d want 25", data_o); end
      cmd = 0;
      step();
      checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL acc_start_count got %0d want 1", start_cnt - s0); end
   endtask

   task automatic test_reject_rearm();
      int s0;
      s0 = start_cnt;
      cmd = 3;
      repeat (5) step();
      checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL rej_held_start got %0d want 1", start_cnt - s0); end
      checks++; if (status !== 1) begin errors++; $display("FAIL rej_running got %0h want 1", status); end
      cmd = 5;
      step();
      checks++; if (data_o !== 4) begin errors++; $display("FAIL rej_counter_restart got %0d want 4", data_o); end
      cmd = 0; engine_done = 1; engine_accept = 0;
      step();
      engine_done = 0;
      checks++; if (status !== 3) begin errors++; $display("FAIL rej_status got %0h want 3", status); end
   endtask

   task automatic test_guards();
      int w0, s0;
      scc = 32'h40; ecc = 32'h4F; cmd = 3;
      step();
      checks++; if (status !== 1) begin errors++; $display("FAIL grd_running got %0h want 1", status); end
      w0 = we_cnt;
      cmd = 1; addr = 5; din = 32'hDEAD;
      step();
      checks++; if (mem_we !== 0) begin errors++; $display("FAIL grd_we got %b want 0", mem_we); end
      step(); step();
      checks++; if (we_cnt !== w0) begin errors++; $display("FAIL grd_we_count got %0d want %0d", we_cnt, w0); end
      cmd = 4;
      step();
      checks++; if (status !== 0) begin errors++; $display("FAIL grd_reset got %0h want 0", status); end
      cmd = 0;
      step();
      s0 = start_cnt;
      scc = 32'h20; ecc = 32'h10; cmd = 3;
      step();
      checks++; if (status !== 4 || engine_start !== 0) begin errors++; $display("FAIL grd_error got st=%0h pulse=%b want 4/0", status, engine_start); end
      cmd = 0;
      step();
      checks++; if (start_cnt !== s0 || start_cc !== 32'h40) begin errors++; $display("FAIL grd_no_start got cnt=%0d cc=%0h want %0d/40", start_cnt, start_cc, s0); end
   endtask

   task automatic test_reset_vs_done();
      int a0;
      scc = 32'h10; ecc = 32'h20; cmd = 3;
      step();
      checks++; if (status !== 1) begin errors++; $display("FAIL rvd_running got %0h want 1", status); end
      cmd = 0;
      repeat (4) step();
      cmd = 5;
      step();
      checks++; if (data_o !== 4) begin errors++; $display("FAIL rvd_snapshot got %0d want 4", data_o); end
      a0 = abort_cnt;
      cmd = 4; engine_done = 1; engine_accept = 1;
      step();
      engine_done = 0; engine_accept = 0;
      checks++; if (status !== 0 || engine_abort !== 1) begin errors++; $display("FAIL rvd_reset got st=%0h abort=%b want 0/1", status, engine_abort); end
      checks++; if (data_o !== 0) begin errors++; $display("FAIL rvd_data_clr got %0d want 0", data_o); end
      cmd = 5;
      step();
      checks++; if (data_o !== 0 || engine_abort !== 0) begin errors++; $display("FAIL rvd_counter got cnt=%0d abort=%b want 0/0", data_o, engine_abort); end
      checks++; if (abort_cnt - a0 !== 1) begin errors++; $display("FAIL rvd_abort_count got %0d want 1", abort_cnt - a0); end
      cmd = 0;
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = '0;
      rst_n = 1'b0; cmd = 0; addr = 0; din = 0; scc = 0; ecc = 0;
      engine_done = 0; engine_accept = 0;
      test_reset();
      test_reset_mid_run();
      test_write_read();
      test_accept();
      test_reject_rearm();
      test_guards();
      test_reset_vs_done();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
